// File: rtl/fp_pkg.sv
// Shared op codes, sequencer state encoding and op-latency helper for the FP issue stage.
package fp_pkg;

    localparam logic [3:0] FP_ADD   = 4'b0000;
    localparam logic [3:0] FP_SUB   = 4'b0001;
    localparam logic [3:0] FP_MUL   = 4'b0010;
    localparam logic [3:0] FP_DIV   = 4'b0011;
    localparam logic [3:0] FP_FLOOR = 4'b0100;
    localparam logic [3:0] FP_ABS   = 4'b0101;
    localparam logic [3:0] FP_SQRT  = 4'b0110;
    localparam logic [3:0] FP_ATAN  = 4'b0111;
    // Any code with bit 3 set is a move; this is the canonical one.
    localparam logic [3:0] FP_MOVE  = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WAIT = 2'd2,
        ST_WB   = 2'd3
    } fp_state_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] in1;
        logic [15:0] in2;
    } fp_opnd_t;

    // atan goes through a registered LUT in the FP unit and needs one more cycle.
    function automatic logic fp_extra_wait(input logic [3:0] op);
        return op == FP_ATAN;
    endfunction

endpackage

// File: rtl/fp_regfile.sv
// fp16 register file: one write port, three combinational read ports.
// Latency: write visible on reads the cycle after the write edge.
// Backpressure: none; the caller arbitrates the single write port.
module fp_regfile #(
    parameter int NREGS = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr1,
    output logic [15:0]   rdata1,
    input  logic [AW-1:0] raddr2,
    output logic [15:0]   rdata2,
    input  logic [AW-1:0] dbg_addr,
    output logic [15:0]   dbg_data
);

    logic [15:0] mem [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= 16'h0000;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1   = mem[raddr1];
    assign rdata2   = mem[raddr2];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/fp_issue.sv
// Sequences one FP instruction at a time: read sources, drive FP unit, write result back.
// Latency: accept to writeback 2 edges (3 for atan); one instruction per 3 (4) cycles.
// Backpressure: instr_ready only in IDLE; host loads yield to a same-cycle instruction.
module fp_issue
    import fp_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [3:0]    instr_op,
    input  logic [AW-1:0] instr_rd,
    input  logic [AW-1:0] instr_rs1,
    input  logic [AW-1:0] instr_rs2,
    output logic [3:0]    fpu_op,
    output logic [15:0]   fpu_in1,
    output logic [15:0]   fpu_in2,
    input  logic [15:0]   fpu_out,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [15:0]   ld_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [15:0]   dbg_data,
    output logic          done,
    output logic          busy
);

    fp_state_t     state;
    fp_opnd_t      opnd_q;
    logic [AW-1:0] rd_q;
    logic [15:0]   res_q;
    logic [15:0]   rs1_dat;
    logic [15:0]   rs2_dat;
    logic          wb_we;
    logic          ld_fire;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [15:0]   rf_wdata;

    assign instr_ready = (state == ST_IDLE) && !rst;
    assign ld_ready    = (state == ST_IDLE) && !instr_valid && !rst;
    assign busy        = (state != ST_IDLE);

    // Operand register doubles as the FP unit drive, so it holds between instructions.
    assign fpu_op  = opnd_q.op;
    assign fpu_in1 = opnd_q.in1;
    assign fpu_in2 = opnd_q.in2;

    assign wb_we    = (state == ST_WB);
    assign ld_fire  = ld_valid && ld_ready;
    assign rf_we    = wb_we || ld_fire;
    assign rf_waddr = wb_we ? rd_q  : ld_addr;
    assign rf_wdata = wb_we ? res_q : ld_data;

    fp_regfile #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .raddr1   (instr_rs1),
        .rdata1   (rs1_dat),
        .raddr2   (instr_rs2),
        .rdata2   (rs2_dat),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            opnd_q <= '0;
            rd_q   <= '0;
            res_q  <= 16'h0000;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        opnd_q <= '{op: instr_op, in1: rs1_dat, in2: rs2_dat};
                        rd_q   <= instr_rd;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (fp_extra_wait(opnd_q.op)) begin
                        state <= ST_WAIT;
                    end else begin
                        res_q <= fpu_out;
                        done  <= 1'b1;
                        state <= ST_WB;
                    end
                end
                ST_WAIT: begin
                    res_q <= fpu_out;
                    done  <= 1'b1;
                    state <= ST_WB;
                end
                ST_WB: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_issue.sv
// Directed bench for fp_issue with a tiny table-driven FP unit model.
module tb_fp_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_op;
    logic [3:0]  instr_rd;
    logic [3:0]  instr_rs1;
    logic [3:0]  instr_rs2;
    logic [3:0]  fpu_op;
    logic [15:0] fpu_in1;
    logic [15:0] fpu_in2;
    logic [15:0] fpu_out;
    logic        ld_valid;
    logic        ld_ready;
    logic [3:0]  ld_addr;
    logic [15:0] ld_data;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic        done;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    fp_issue #(.NREGS(16), .AW(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs1   (instr_rs1),
        .instr_rs2   (instr_rs2),
        .fpu_op      (fpu_op),
        .fpu_in1     (fpu_in1),
        .fpu_in2     (fpu_in2),
        .fpu_out     (fpu_out),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .done        (done),
        .busy        (busy)
    );

    // FP unit model: only the operand pairs used below; atan answers one cycle late.
    logic [15:0] atan_q;

    function automatic logic [15:0] fpu_comb(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        if (op[3]) return a;
        case (op)
            4'd0:    return (a == 16'h3E00 && b == 16'h4000) ? 16'h4300 : 16'hDEAD;
            4'd1:    return (a == b) ? 16'h0000 : 16'hDEAD;
            4'd2:    return (a == 16'h3E00 && b == 16'h4000) ? 16'h4200 : 16'hDEAD;
            4'd5:    return {1'b0, a[14:0]};
            default: return 16'hDEAD;
        endcase
    endfunction

    always @(posedge clk) begin
        atan_q   <= (fpu_in1 == 16'h4000) ? 16'h3C6E : 16'hBAD0;
        cyc      <= cyc + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    assign fpu_out = (fpu_op == 4'd7) ? atan_q : fpu_comb(fpu_op, fpu_in1, fpu_in2);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [3:0] a, input logic [15:0] exp);
        dbg_addr = a;
        #1;
        check(tag, {16'h0, dbg_data}, {16'h0, exp});
    endtask

    // Called at a negedge in IDLE with no instruction pending.
    task automatic load(input logic [3:0] a, input logic [15:0] d);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        @(posedge clk);
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    // Offers an instruction and returns at the negedge following the accept edge, valid still high.
    task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                         input logic [3:0] rs2, output int acc);
        bit ok;
        ok          = 1'b0;
        acc         = -1;
        instr_op    = op;
        instr_rd    = rd;
        instr_rs1   = rs1;
        instr_rs2   = rs2;
        instr_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (instr_ready) begin
                @(posedge clk);
                @(negedge clk);
                acc = cyc;
                ok  = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, base, n;

        rst         = 1'b1;
        instr_valid = 1'b0;
        instr_op    = 4'd0;
        instr_rd    = 4'd0;
        instr_rs1   = 4'd0;
        instr_rs2   = 4'd0;
        ld_valid    = 1'b0;
        ld_addr     = 4'd0;
        ld_data     = 16'h0;
        dbg_addr    = 4'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_instr_ready", {31'b0, instr_ready}, 32'd0);
        check("rst_ld_ready", {31'b0, ld_ready}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_fpu", {12'b0, fpu_op, fpu_in1}, 32'd0);
        rst = 1'b0;
        #1;
        check("rel_instr_ready", {31'b0, instr_ready}, 32'd1);
        @(negedge clk);

        // Reset mid-EXEC aborts and clears the register file
        load(4'd1, 16'h3E00);
        check_reg("preload_r1", 4'd1, 16'h3E00);
        @(negedge clk);
        base = done_cnt;
        issue(4'd0, 4'd3, 4'd1, 4'd2, a1);
        instr_valid = 1'b0;
        check("abort_busy_exec", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_busy_in_rst", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        check("abort_no_done", done_cnt - base, 32'd0);
        check_reg("abort_r1_cleared", 4'd1, 16'h0000);
        check_reg("abort_r3_clear", 4'd3, 16'h0000);
        check("abort_ready_after", {31'b0, instr_ready}, 32'd1);
        @(negedge clk);

        // Add: r3 = r1 + r2
        load(4'd1, 16'h3E00);
        load(4'd2, 16'h4000);
        base = done_cnt;
        issue(4'd0, 4'd3, 4'd1, 4'd2, a1);
        instr_valid = 1'b0;
        check("add_fpu_op", {28'b0, fpu_op}, 32'd0);
        check("add_fpu_in", {fpu_in1, fpu_in2}, 32'h3E00_4000);
        check("add_done_exec", {31'b0, done}, 32'd0);
        check_reg("add_r3_exec", 4'd3, 16'h0000);
        @(negedge clk);
        check("add_done_wb", {31'b0, done}, 32'd1);
        check_reg("add_r3_wb", 4'd3, 16'h0000);
        @(negedge clk);
        check_reg("add_r3", 4'd3, 16'h4300);
        check("add_done_idle", {31'b0, done}, 32'd0);
        check("add_busy_idle", {31'b0, busy}, 32'd0);
        check("add_done_count", done_cnt - base, 32'd1);

        // Back-to-back mul then move with valid held high
        issue(4'd2, 4'd4, 4'd1, 4'd2, a1);
        issue(4'd8, 4'd5, 4'd4, 4'd0, a2);
        instr_valid = 1'b0;
        check("b2b_spacing", a2 - a1, 32'd3);
        wait_idle();
        check_reg("mul_r4", 4'd4, 16'h4200);
        check_reg("move_r5", 4'd5, 16'h4200);
        @(negedge clk);

        // atan: extra WAIT cycle, operands held
        issue(4'd7, 4'd6, 4'd2, 4'd0, a1);
        instr_valid = 1'b0;
        check("atan_exec", {busy, 11'b0, fpu_op, fpu_in1}, {1'b1, 11'b0, 4'd7, 16'h4000});
        check_reg("atan_r6_exec", 4'd6, 16'h0000);
        @(negedge clk);
        check("atan_wait", {busy, done, 14'b0, fpu_in1}, {1'b1, 1'b0, 14'b0, 16'h4000});
        @(negedge clk);
        check("atan_wb", {busy, done, 14'b0, fpu_in1}, {1'b1, 1'b1, 14'b0, 16'h4000});
        check_reg("atan_r6_wb", 4'd6, 16'h0000);
        @(negedge clk);
        check("atan_busy_end", {31'b0, busy}, 32'd0);
        check_reg("atan_r6", 4'd6, 16'h3C6E);

        // Aliasing: r2 = abs(r2), r1 = r1 - r1
        load(4'd2, 16'hC000);
        issue(4'd5, 4'd2, 4'd2, 4'd2, a1);
        instr_valid = 1'b0;
        wait_idle();
        check_reg("abs_r2", 4'd2, 16'h4000);
        issue(4'd1, 4'd1, 4'd1, 4'd1, a1);
        instr_valid = 1'b0;
        wait_idle();
        check_reg("sub_r1", 4'd1, 16'h0000);
        @(negedge clk);

        // Load vs instruction in the same IDLE cycle
        ld_valid    = 1'b1;
        ld_addr     = 4'd8;
        ld_data     = 16'h1234;
        instr_op    = 4'd8;
        instr_rd    = 4'd9;
        instr_rs1   = 4'd2;
        instr_rs2   = 4'd0;
        instr_valid = 1'b1;
        #1;
        check("arb_ready", {30'b0, instr_ready, ld_ready}, 32'b10);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        check("arb_busy", {31'b0, busy}, 32'd1);
        check_reg("arb_r8_held", 4'd8, 16'h0000);
        n = 0;
        while (!ld_ready && n < 10) begin
            n++;
            @(negedge clk);
        end
        check("arb_ld_wait", n, 32'd2);
        @(posedge clk);
        @(negedge clk);
        ld_valid = 1'b0;
        check_reg("arb_r8", 4'd8, 16'h1234);
        check_reg("arb_r9", 4'd9, 16'h4000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_issue.md
# fp_issue

Sequencing stage directly upstream of the floating-point unit. Accepts one scalar FP instruction at a time over a valid/ready handshake and reads both source operands from a local 16 × fp16 register file. Drives the FP unit's `op`/`in1`/`in2`, waits the op-dependent latency (arctan uses a registered LUT), and writes the result back to the destination register. It is the only writer of FP registers apart from a host load port used to preload constants.

## Interface
Parameters:
- `NREGS`, 16: number of fp16 registers.
- `AW`, 4: register address width; `NREGS == 2**AW`.

Ports:
- `clk`: input, 1. Single clock, all state on the rising edge.
- `rst`: input, 1. Asynchronous, active-high reset.
- `instr_valid`: input, 1. Instruction offered.
- `instr_ready`: output, 1. Equals `state==IDLE && !rst`.
- `instr_op`: input, 4. Operation code (see Operation).
- `instr_rd`, `instr_rs1`, `instr_rs2`: input, AW each. Destination and source register addresses.
- `fpu_op`: output, 4. To the FP unit.
- `fpu_in1`, `fpu_in2`: output, 16 each. To the FP unit.
- `fpu_out`: input, 16. Result from the FP unit.
- `ld_valid`: input, 1. Host register write request.
- `ld_ready`: output, 1. Equals `state==IDLE && !instr_valid`; instruction accept takes priority.
- `ld_addr`: input, AW. Host write address.
- `ld_data`: input, 16. Host write data.
- `dbg_addr`: input, AW. Debug read address.
- `dbg_data`: output, 16. Combinational read of `reg[dbg_addr]`.
- `done`: output, 1. One-cycle pulse in the WB state.
- `busy`: output, 1. High when `state != IDLE`.

## Operation
- Op codes:
  - `4'b1xxx`: move (result = in1).
  - `0000`: add. `0001`: sub. `0010`: mul. `0011`: div.
  - `0100`: floor. `0101`: abs. `0110`: sqrt. `0111`: atan.
- FSM states:
  - IDLE: on `instr_valid && instr_ready`, latch `op`, `rd`, `reg[rs1]` and `reg[rs2]` into operand registers, then go to EXEC.
  - EXEC: `fpu_op`/`fpu_in1`/`fpu_in2` are driven from the operand registers. If `op==0111`, go to WAIT. Otherwise capture `fpu_out` into `res`, then go to WB.
  - WAIT (atan only): operands are still held. Capture `fpu_out` into `res`, then go to WB.
  - WB: write `reg[rd] <= res`, assert `done`, return to IDLE.
- Operands are held stable on the `fpu_*` outputs from EXEC through WAIT. Outside these states the outputs keep their last values.
- `rs1==rd` or `rs2==rd` is legal; sources are read at accept, before writeback.
- Host load: `ld_valid && ld_ready` writes `reg[ld_addr] <= ld_data` at that edge. A same-cycle `instr_valid` blocks the load, so the two never conflict.
- The register file is written at the WB edge only. `dbg_data` shows the new value from the next cycle.

## Timing
- Reset value of every output and register is zero: `reg[*]=16'h0000`, `fpu_op=0`, `fpu_in*=0`, `res=0`, `done=0`, `busy=0`, and state IDLE.
- `instr_ready`/`ld_ready` are 0 while `rst` is high and follow their formulas from the first cycle after deassertion.
- Latency from the accept edge T to the register write edge:
  - Non-atan ops: T+2 (EXEC at T+1, WB at T+2). `done` is high during the cycle after edge T+1.
  - atan: T+3.
- Throughput: one instruction per 3 cycles (4 cycles for atan). A back-to-back `instr_valid` is accepted in the IDLE cycle following WB.
- `instr_valid` without `instr_ready` is ignored; the source must hold its request.
- Reset mid-operation: the in-flight instruction is aborted with no writeback. The register file is cleared and `done` is not pulsed.
- `instr_op` values outside the defined codes cannot occur, since every 4-bit code is mapped.

## Structure
- Shared package `fp_pkg`: op-code localparams (`FP_ADD`…`FP_MOVE`), the FSM state encoding, and a function `fp_extra_wait(op)` that returns 1 for atan.
- One natural sub-module, `fp_regfile`: NREGS×16, asynchronous reset.
  - One write port (muxed WB / host load).
  - Three combinational read ports (rs1, rs2, dbg).

## Test plan
- Reset: preload `r1=16'h3E00`, assert `rst` mid-EXEC of an add → all registers read 0 via dbg, `done` never pulses, `instr_ready` goes to 1 after release.
- Add: `r1=3E00` (1.5), `r2=4000` (2.0), add `r3=r1+r2` → `reg[3]==16'h4300` two edges after accept, one `done` pulse.
- Mul then move, back-to-back with `instr_valid` held high: `r4=r1*r2` → `4200`; `r5=move r4` → `4200`. Second accept occurs exactly 3 cycles after the first.
- atan: `r6=atan(r2)` → `busy` lasts 3 cycles, write lands at T+3, and `fpu_in1` stays `4000` through EXEC and WAIT.
- Aliasing: `r2=abs(r2)` with `r2=C000` → `reg[2]==4000`; `r1=r1-r1` → `0000`.
- Load arbitration: `ld_valid` and `instr_valid` in the same IDLE cycle → the instruction is accepted and the load is held off (`ld_ready=0`), then completes in the IDLE cycle after WB.
